// File: rtl/alu_wb_stage.sv
// ALU writeback pipeline register: captures the ALU result and flags under a
// valid/ready handshake. It also holds the {N,Z,C,V} status register, resolves
// conditional branches and counts retired operations.
module alu_wb_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 4,
  parameter int unsigned PCW   = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow,
  input  logic             alu_negative,
  input  logic             alu_eq,
  input  logic             alu_bgt,
  input  logic [RADDR-1:0] rd_addr,
  input  logic             wr_en_in,
  input  logic             set_flags,
  input  logic [1:0]       br_type,
  input  logic [PCW-1:0]   br_target,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RADDR-1:0] out_rd,
  output logic             out_wr_en,
  output logic [3:0]       flags_q,
  output logic             branch_taken,
  output logic [PCW-1:0]   branch_pc,
  output logic [CNTW-1:0]  retired
);

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_GT   = 2'b10;
  localparam logic [1:0] BR_NE   = 2'b11;

  localparam logic [CNTW-1:0] RETIRED_MAX = '1;

  logic accept_c;
  logic taken_c;

  // Handshake: slot is free when empty or being drained this cycle.
  always_comb begin
    in_ready = !out_valid || out_ready;
    accept_c = in_valid && in_ready && !flush;
  end

  // Branch resolution for the operation being accepted.
  always_comb begin
    taken_c = 1'b0;
    if (accept_c) begin
      unique case (br_type)
        BR_EQ:   taken_c = alu_eq;
        BR_GT:   taken_c = alu_bgt;
        BR_NE:   taken_c = !alu_eq;
        default: taken_c = 1'b0;
      endcase
    end
  end

  // Held entry: load on accept, clear on flush or drain without refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_rd     <= '0;
      out_wr_en  <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (accept_c) begin
      out_valid  <= 1'b1;
      out_result <= alu_result;
      out_rd     <= rd_addr;
      out_wr_en  <= wr_en_in && (br_type == BR_NONE);
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Architectural status register {N,Z,C,V}.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q <= '0;
    end else if (accept_c && set_flags) begin
      flags_q <= {alu_negative, alu_zero, alu_carry, alu_overflow};
    end
  end

  // Branch pulse and sticky target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_taken <= 1'b0;
      branch_pc    <= '0;
    end else begin
      branch_taken <= taken_c;
      if (taken_c) begin
        branch_pc <= br_target;
      end
    end
  end

  // Saturating retired-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired <= '0;
    end else if (accept_c && (retired != RETIRED_MAX)) begin
      retired <= retired + CNTW'(1);
    end
  end

endmodule
